// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber polyvec accumulate/reduce path.
package kyber_pkg;

    localparam int KYBER_N          = 256;
    localparam int KYBER_K          = 3;
    localparam int KYBER_Q          = 3329;
    localparam int KYBER_POLY_WIDTH = 16;
    localparam int BARRETT_V        = 20159;

    // Buffer depth in coefficient pairs.
    localparam int KYBER_PAIRS      = KYBER_N / 2;

    typedef logic signed [KYBER_POLY_WIDTH-1:0] coeff_t;

    typedef struct packed {
        coeff_t c0;
        coeff_t c1;
    } coeff_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } acc_state_t;

endpackage

// File: rtl/poly_acc_reduce_barrett.sv
// Combinational signed Barrett reduction of one coefficient modulo Q.
// Output lies in [-(Q-1)/2, (Q-1)/2] for |a| well inside the 16-bit range.
module barrett_reduce
    import kyber_pkg::*;
(
    input  coeff_t a,
    output coeff_t r
);

    localparam logic signed [31:0] V_32   = 32'(BARRETT_V);
    localparam logic signed [31:0] Q_32   = 32'(KYBER_Q);
    localparam logic signed [31:0] RND_32 = 32'sd33554432;

    logic signed [31:0] a_32;

    // Quotient estimate a*V/2^26 rounded to nearest, then subtract quotient*Q.
    always_comb begin
        a_32 = 32'(a);
        r    = coeff_t'(a_32 - (((a_32 * V_32) + RND_32) >>> 26) * Q_32);
    end

endmodule

// File: rtl/poly_acc_reduce.sv
// Pointwise accumulation of KYBER_K basemul polynomials into a pair buffer,
// followed by a streamed readout toward the inverse NTT.
// Build option: POLY_ACC_BARRETT_EN -- when defined the streamed sums are
// Barrett-reduced; when undefined the raw accumulated sums are streamed with
// identical latency and handshake (for a lazily reducing downstream stage).
module poly_acc_reduce
    import kyber_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [KYBER_POLY_WIDTH-1:0] in_coeff0,
    input  logic signed [KYBER_POLY_WIDTH-1:0] in_coeff1,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [6:0]                         out_idx,
    output logic signed [KYBER_POLY_WIDTH-1:0] out_coeff0,
    output logic signed [KYBER_POLY_WIDTH-1:0] out_coeff1,
    output logic                               busy,
    output logic                               done
);

    localparam int K_W = (KYBER_K > 1) ? $clog2(KYBER_K) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(KYBER_K - 1);

    acc_state_t     state_q;
    acc_state_t     state_d;

    logic [6:0]     p_q;        // accumulate pair address
    logic [K_W-1:0] k_q;        // polynomial index within the run
    logic [7:0]     q_q;        // stream load counter, bit 7 = all pairs loaded

    coeff_pair_t    acc_mem [KYBER_PAIRS];

    logic           in_fire;
    logic           last_in;
    logic           out_fire;
    logic           last_out;
    logic           load_out;
    logic [6:0]     rd_addr;
    coeff_pair_t    rd_pair_p0;
    coeff_pair_t    acc_pair_p0;
    coeff_t         red0_p0;
    coeff_t         red1_p0;

    // Handshake and sequencing decodes.
    always_comb begin
        in_fire  = in_valid && (state_q == ST_ACCUM);
        last_in  = in_fire && (p_q == 7'd127) && (k_q == K_LAST);
        out_fire = out_valid && out_ready;
        last_out = out_fire && (out_idx == 7'd127);
        load_out = (state_q == ST_STREAM) && !q_q[7] && (!out_valid || out_ready);
        in_ready = (state_q == ST_ACCUM);
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
    end

    // ---- stage 0: buffer read, accumulate sum and output reduction ----

    // One read port shared by the accumulate RMW and the stream readout.
    always_comb begin
        rd_addr    = (state_q == ST_STREAM) ? q_q[6:0] : p_q;
        rd_pair_p0 = acc_mem[rd_addr];
    end

    // First polynomial overwrites the slot, so stale contents never leak in.
    always_comb begin
        acc_pair_p0.c0 = in_coeff0 + ((k_q == '0) ? coeff_t'(0) : rd_pair_p0.c0);
        acc_pair_p0.c1 = in_coeff1 + ((k_q == '0) ? coeff_t'(0) : rd_pair_p0.c1);
    end

`ifdef POLY_ACC_BARRETT_EN
    barrett_reduce u_red0 (
        .a (rd_pair_p0.c0),
        .r (red0_p0)
    );

    barrett_reduce u_red1 (
        .a (rd_pair_p0.c1),
        .r (red1_p0)
    );
`else
    // Lazy-reduction build: stream the raw sums.
    always_comb begin
        red0_p0 = rd_pair_p0.c0;
        red1_p0 = rd_pair_p0.c1;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)    state_d = ST_ACCUM;
            ST_ACCUM:  if (last_in)  state_d = ST_STREAM;
            ST_STREAM: if (last_out) state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Accumulate and stream counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            k_q <= '0;
            q_q <= '0;
        end else begin
            if (in_fire) begin
                p_q <= p_q + 7'd1;
                if (p_q == 7'd127) begin
                    k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
                end
            end
            if (state_q == ST_ACCUM) begin
                q_q <= '0;
            end else if (load_out) begin
                q_q <= q_q + 8'd1;
            end
        end
    end

    // Pair buffer write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            acc_mem[p_q] <= acc_pair_p0;
        end
    end

    // ---- stage 1: output registers, held while downstream stalls ----

    // Load on an empty slot or on a transfer; drain after the final pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_coeff0 <= '0;
            out_coeff1 <= '0;
        end else if (load_out) begin
            out_valid  <= 1'b1;
            out_idx    <= q_q[6:0];
            out_coeff0 <= red0_p0;
            out_coeff1 <= red1_p0;
        end else if (out_fire) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_acc_reduce.sv
// Randomized self-checking bench for poly_acc_reduce against a plain
// arithmetic model (sum of polynomials, then centred residue mod Q when
// POLY_ACC_BARRETT_EN is defined).
module tb_poly_acc_reduce;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_coeff0;
    logic signed [15:0] in_coeff1;
    logic               out_valid;
    logic               out_ready;
    logic [6:0]         out_idx;
    logic signed [15:0] out_coeff0;
    logic signed [15:0] out_coeff1;
    logic               busy;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;
    int poly [3][256];

    poly_acc_reduce dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coeff0  (in_coeff0),
        .in_coeff1  (in_coeff1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_coeff0 (out_coeff0),
        .out_coeff1 (out_coeff1),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_out(input int s);
`ifdef POLY_ACC_BARRETT_EN
        int r;
        r = s % 3329;
        if (r > 1664) r -= 3329;
        else if (r < -1664) r += 3329;
        return r;
`else
        return s;
`endif
    endfunction

    function automatic int rnd_coeff();
        return int'($urandom_range(6656)) - 3328;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 256; n++)
                poly[k][n] = rnd_coeff();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_out_idx"}, out_idx, 0);
        check({pfx, "_out_c0"}, out_coeff0, 0);
        check({pfx, "_out_c1"}, out_coeff1, 0);
        check({pfx, "_in_ready"}, in_ready, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
    endtask

    // One run: feed poly[][] with random gaps, drain with random stalls.
    task automatic run(input int gap_pct, input int rdy_pct, input int abort_at,
                       input bit poke_start);
        int  e0 [128];
        int  e1 [128];
        int  in_cnt, out_cnt, done_cnt, cyc, last_in_cyc, first_vld_cyc;
        int  h_idx, h_c0, h_c1;
        bit  finished, prev_stall;
        for (int i = 0; i < 128; i++) begin
            int s0, s1;
            s0 = 0; s1 = 0;
            for (int k = 0; k < 3; k++) begin
                s0 += poly[k][2*i];
                s1 += poly[k][2*i+1];
            end
            e0[i] = model_out(s0);
            e1[i] = model_out(s1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        in_cnt = 0; out_cnt = 0; done_cnt = 0; cyc = 0;
        last_in_cyc = -1; first_vld_cyc = -1;
        h_idx = 0; h_c0 = 0; h_c1 = 0;
        finished = 1'b0; prev_stall = 1'b0;
        while (!finished && cyc < 4000) begin
            if (abort_at > 0 && in_cnt == abort_at) break;
            in_valid  = 1'b0;
            in_coeff0 = 16'(rnd_coeff());
            in_coeff1 = 16'(rnd_coeff());
            if (in_cnt < 384 && int'($urandom_range(99)) >= gap_pct) begin
                in_valid  = 1'b1;
                in_coeff0 = 16'(poly[in_cnt/128][2*(in_cnt%128)]);
                in_coeff1 = 16'(poly[in_cnt/128][2*(in_cnt%128)+1]);
            end
            out_ready = (int'($urandom_range(99)) < rdy_pct);
            start     = poke_start && (in_cnt == 100);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_idx", out_idx, h_idx);
                check("stall_c0", out_coeff0, h_c0);
                check("stall_c1", out_coeff1, h_c1);
            end
            prev_stall = 1'b0;
            if (out_valid) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (out_ready) begin
                    check("out_idx", out_idx, out_cnt % 128);
                    check("out_c0", out_coeff0, e0[out_cnt % 128]);
                    check("out_c1", out_coeff1, e1[out_cnt % 128]);
                    out_cnt++;
                end else begin
                    prev_stall = 1'b1;
                    h_idx = out_idx; h_c0 = out_coeff0; h_c1 = out_coeff1;
                end
            end
            if (done) begin
                check("done_after_last", out_cnt, 128);
                check("busy_in_done", busy, 1);
                done_cnt++;
                finished = 1'b1;
                start = poke_start;
            end
            if (in_valid && in_ready) begin
                in_cnt++;
                if (in_cnt == 384) last_in_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (abort_at == 0) begin
            check("run_timeout", finished, 1);
            check("out_count", out_cnt, 128);
            check("done_pulses", done_cnt, 1);
            check("first_out_latency", first_vld_cyc - last_in_cyc, 2);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_in_ready", in_ready, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_coeff0 = '0; in_coeff1 = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Constant patterns (1,-1), (2,-2), (3,-3), full throughput.
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 256; n++)
                poly[k][n] = (n % 2 == 0) ? (k + 1) : -(k + 1);
        run(0, 100, 0, 1'b0);

        // Largest positive and negative sums.
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 256; n++)
                poly[k][n] = 3328;
        run(0, 100, 0, 1'b0);
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 256; n++)
                poly[k][n] = -3328;
        run(0, 100, 0, 1'b0);

        // Rounding boundary at Q/2: 1665 and 1664 in poly0 only.
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 256; n++)
                poly[k][n] = (k != 0) ? 0 : ((n % 2 == 0) ? 1665 : 1664);
        run(0, 100, 0, 1'b0);

        // Random data, input gaps, 50% output stalls, stray start pulses.
        fill_random();
        run(30, 50, 0, 1'b1);

        // in_valid with junk while idle must not touch the buffer.
        for (int c = 0; c < 6; c++) begin
            in_valid  = 1'b1;
            in_coeff0 = 16'(rnd_coeff());
            in_coeff1 = 16'(rnd_coeff());
            @(negedge clk);
            check("idle_ready_junk", in_ready, 0);
        end
        in_valid = 1'b0;
        fill_random();
        run(20, 70, 0, 1'b0);

        // Abort after 200 input beats, then a fresh run over the stale buffer.
        fill_random();
        run(10, 100, 200, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_rst");
        rst = 1'b0;
        @(negedge clk);
        fill_random();
        run(25, 60, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
